// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-through, no-write-allocate cache controller (optional CACHE_STATS_EN hit/miss counters)
module dm_cache_ctrl #(
    parameter int BLOCKS = 256,
    parameter int WORDS  = 16,
    parameter int SIZE   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_we,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic [SIZE-1:0]                   req_wdata,
    output logic                              rsp_valid,
    output logic [SIZE-1:0]                   rsp_rdata,
    output logic                              mem_rd_req,
    output logic [ADDR_W-$clog2(WORDS)-1:0]   mem_rd_addr,
    input  logic                              mem_rd_valid,
    input  logic [SIZE*WORDS-1:0]             mem_rd_data,
    output logic                              mem_wr_valid,
    output logic [ADDR_W-1:0]                 mem_wr_addr,
    output logic [SIZE-1:0]                   mem_wr_data,
    input  logic                              mem_wr_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                       hit_cnt,
    output logic [31:0]                       miss_cnt
`endif
);

    localparam int IDX_W  = $clog2(BLOCKS);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = SIZE * WORDS;
    localparam int BASE_W = $clog2(LINE_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_WRITE
    } state_t;

    state_t state_q, state_d;

    // Latched request; everything after IDLE works from these copies
    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [SIZE-1:0]   req_wdata_q;

    // Set once the line for the current request has been refilled, so the
    // follow-up LOOKUP hit is not counted as an original hit
    logic              refilled_q;

    // Line storage: only the valid bits need reset
    logic [BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]  tag_mem  [BLOCKS];
    logic [LINE_W-1:0] data_mem [BLOCKS];

    logic              rsp_valid_q;
    logic [SIZE-1:0]   rsp_rdata_q;

    // Decoded fields of the latched address
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic [BASE_W-1:0] word_base;
    logic [LINE_W-1:0] line_rd;
    logic [SIZE-1:0]   hit_word;
    logic              hit;

    // FSM action strobes
    logic              latch_req;
    logic              fill_en;
    logic              wr_hit_en;
    logic              rsp_rd_set;
    logic              rsp_wr_set;
    logic              cnt_hit;
    logic              cnt_miss;

    assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx   = req_addr_q[OFF_W +: IDX_W];
    assign req_off   = req_addr_q[OFF_W-1:0];
    assign word_base = BASE_W'(req_off) * BASE_W'(SIZE);
    assign line_rd   = data_mem[req_idx];
    assign hit_word  = line_rd[word_base +: SIZE];
    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and action decode
    always_comb begin
        state_d    = state_q;
        latch_req  = 1'b0;
        fill_en    = 1'b0;
        wr_hit_en  = 1'b0;
        rsp_rd_set = 1'b0;
        rsp_wr_set = 1'b0;
        cnt_hit    = 1'b0;
        cnt_miss   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    latch_req = 1'b1;
                    state_d   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (req_we_q) begin
                    wr_hit_en = hit;
                    cnt_hit   = hit;
                    cnt_miss  = !hit;
                    state_d   = S_WRITE;
                end else if (hit) begin
                    rsp_rd_set = 1'b1;
                    cnt_hit    = !refilled_q;
                    state_d    = S_IDLE;
                end else begin
                    cnt_miss = 1'b1;
                    state_d  = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_rd_valid) begin
                    fill_en = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_WRITE: begin
                if (mem_wr_ready) begin
                    rsp_wr_set = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else if (latch_req) begin
            req_we_q    <= req_we;
            req_addr_q  <= req_addr;
            req_wdata_q <= req_wdata;
        end
    end

    // Track whether the current request already went through a refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refilled_q <= 1'b0;
        end else if (latch_req) begin
            refilled_q <= 1'b0;
        end else if (fill_en) begin
            refilled_q <= 1'b1;
        end
    end

    // Valid bits: cleared by reset, set by a completed refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[req_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: whole-line fill, or single-word update on a write hit
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= mem_rd_data;
        end else if (wr_hit_en) begin
            data_mem[req_idx][word_base +: SIZE] <= req_wdata_q;
        end
    end

    // Response pulse: read data on a read hit, zero on a write acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_rd_set || rsp_wr_set;
            if (rsp_rd_set) begin
                rsp_rdata_q <= hit_word;
            end else if (rsp_wr_set) begin
                rsp_rdata_q <= '0;
            end
        end
    end

    // Memory-side requests follow the state directly so reset drops them at once
    assign req_ready    = (state_q == S_IDLE);
    assign mem_rd_req   = (state_q == S_REFILL);
    assign mem_rd_addr  = mem_rd_req ? req_addr_q[ADDR_W-1:OFF_W] : '0;
    assign mem_wr_valid = (state_q == S_WRITE);
    assign mem_wr_addr  = mem_wr_valid ? req_addr_q : '0;
    assign mem_wr_data  = mem_wr_valid ? req_wdata_q : '0;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating hit/miss counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (cnt_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (cnt_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - scoreboard bench for dm_cache_ctrl against a request-level cache/memory model
module tb_dm_cache_ctrl;

    localparam int BLOCKS = 256;
    localparam int WORDS  = 16;
    localparam int SIZE   = 32;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = 8;
    localparam int OFF_W  = 4;
    localparam int TAG_W  = 20;

    logic                   clk;
    logic                   rst_n;
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [ADDR_W-1:0]      req_addr;
    logic [SIZE-1:0]        req_wdata;
    logic                   rsp_valid;
    logic [SIZE-1:0]        rsp_rdata;
    logic                   mem_rd_req;
    logic [ADDR_W-OFF_W-1:0] mem_rd_addr;
    logic                   mem_rd_valid;
    logic [SIZE*WORDS-1:0]  mem_rd_data;
    logic                   mem_wr_valid;
    logic [ADDR_W-1:0]      mem_wr_addr;
    logic [SIZE-1:0]        mem_wr_data;
    logic                   mem_wr_ready;
`ifdef CACHE_STATS_EN
    logic [31:0]            hit_cnt;
    logic [31:0]            miss_cnt;
`endif

    dm_cache_ctrl #(
        .BLOCKS(BLOCKS), .WORDS(WORDS), .SIZE(SIZE), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues
    logic [31:0] exp_rsp_q[$];
    logic [27:0] exp_rd_q[$];
    wr_t         exp_wr_q[$];

    // Reference model: backing memory plus per-index residency
    logic [31:0]      mem_m[logic [31:0]];
    bit               mvalid[BLOCKS];
    logic [TAG_W-1:0] mtag[BLOCKS];
    int               exp_hits = 0;
    int               exp_misses = 0;

    // Memory responder controls
    bit auto_rd = 1'b1;
    int rd_delay_force = -1;
    int wr_delay_force = -1;
    int rd_req_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Line-fill responder, with stray mem_rd_valid pulses when no fill is pending
    initial begin : rd_responder
        bit          rd_active;
        int          rd_d;
        logic [27:0] rd_cap;
        rd_active    = 1'b0;
        rd_d         = 0;
        rd_cap       = '0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (!auto_rd) begin
                rd_active = 1'b0;
                continue;
            end
            mem_rd_valid = 1'b0;
            if (mem_rd_req) begin
                if (!rd_active) begin
                    rd_active = 1'b1;
                    rd_req_cnt++;
                    rd_cap = mem_rd_addr;
                    if (exp_rd_q.size() == 0) fail("rd_unexpected");
                    else check("rd_addr", mem_rd_addr, exp_rd_q.pop_front());
                    rd_d = (rd_delay_force >= 0) ? rd_delay_force : $urandom_range(0, 3);
                end else begin
                    check("rd_addr_hold", mem_rd_addr, rd_cap);
                end
                if (rd_d == 0) begin
                    mem_rd_valid = 1'b1;
                    for (int w = 0; w < WORDS; w++) begin
                        logic [31:0] wa;
                        wa = {rd_cap, 4'(w)};
                        mem_rd_data[w*SIZE +: SIZE] = mem_word(wa);
                    end
                    rd_active = 1'b0;
                end else begin
                    rd_d--;
                end
            end else begin
                if (rd_active) begin
                    fail("rd_req_drop");
                    rd_active = 1'b0;
                end
                if ($urandom_range(0, 3) == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = {WORDS{32'($urandom)}};
                end
            end
        end
    end

    // Write-through responder, with stray mem_wr_ready pulses when idle
    initial begin : wr_responder
        bit  wr_active;
        int  wr_d;
        wr_t cap;
        wr_active    = 1'b0;
        wr_d         = 0;
        cap          = '{32'h0, 32'h0};
        mem_wr_ready = 1'b0;
        forever begin
            @(negedge clk);
            mem_wr_ready = 1'b0;
            if (mem_wr_valid) begin
                if (!wr_active) begin
                    wr_active = 1'b1;
                    cap = '{mem_wr_addr, mem_wr_data};
                    if (exp_wr_q.size() == 0) begin
                        fail("wr_unexpected");
                    end else begin
                        wr_t e;
                        e = exp_wr_q.pop_front();
                        check("wr_addr", mem_wr_addr, e.addr);
                        check("wr_data", mem_wr_data, e.data);
                    end
                    wr_d = (wr_delay_force >= 0) ? wr_delay_force : $urandom_range(0, 3);
                end else begin
                    check("wr_addr_hold", mem_wr_addr, cap.addr);
                    check("wr_data_hold", mem_wr_data, cap.data);
                end
                if (wr_d == 0) begin
                    mem_wr_ready = 1'b1;
                    wr_active    = 1'b0;
                end else begin
                    wr_d--;
                end
            end else begin
                if (wr_active) begin
                    fail("wr_valid_drop");
                    wr_active = 1'b0;
                end
                mem_wr_ready = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Response monitor
    initial begin : rsp_monitor
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (exp_rsp_q.size() == 0) fail("rsp_unexpected");
                else check("rsp_rdata", rsp_rdata, exp_rsp_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < BLOCKS; i++) mvalid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        bit               hit;
        int               rd0;
        int               lat;
        int               n;
        idx = addr[OFF_W +: IDX_W];
        tag = addr[31 -: TAG_W];
        hit = mvalid[idx] && (mtag[idx] == tag);
        rd0 = rd_req_cnt;
        if (hit) exp_hits++;
        else exp_misses++;
        if (we) begin
            exp_wr_q.push_back('{addr, wdata});
            mem_m[addr] = wdata;
            exp_rsp_q.push_back(32'h0);
        end else begin
            if (!hit) begin
                exp_rd_q.push_back(addr[31:OFF_W]);
                mvalid[idx] = 1'b1;
                mtag[idx]   = tag;
            end
            exp_rsp_q.push_back(mem_word(addr));
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail("req_ready_timeout");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) fail("rsp_timeout");
        if (!we && hit) check("hit_latency", lat, 2);
        check(we ? "wr_no_fill" : "fill_count", rd_req_cnt - rd0, (!we && !hit) ? 1 : 0);
    endtask

    initial begin : stimulus
        logic [31:0] a;
        int          n;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rst_n     = 1'b1;
        model_reset();

        // Reset state, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_mem_rd_req", mem_rd_req, 0);
        check("rst_mem_rd_addr", mem_rd_addr, 0);
        check("rst_mem_wr_valid", mem_wr_valid, 0);
        check("rst_mem_wr_addr", mem_wr_addr, 0);
        check("rst_mem_wr_data", mem_wr_data, 0);
`ifdef CACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Miss then hit on 0x13, fill arriving with the first mem_rd_req cycle
        mem_m[32'h13] = 32'hDEAD_BEEF;
        rd_delay_force = 0;
        do_req(1'b0, 32'h0000_0013, 32'h0);
        rd_delay_force = -1;
        do_req(1'b0, 32'h0000_0013, 32'h0);

        // Write hit with three wait cycles, then read back
        wr_delay_force = 3;
        do_req(1'b1, 32'h0000_0013, 32'h1234_5678);
        wr_delay_force = -1;
        do_req(1'b0, 32'h0000_0013, 32'h0);

        // Write miss leaves cache unchanged; later read misses
        do_req(1'b1, 32'h0000_5000, 32'hCAFE_0001);
        do_req(1'b0, 32'h0000_5000, 32'h0);

        // Conflicting tags on index 1
        do_req(1'b0, 32'h0001_0010, 32'h0);
        do_req(1'b0, 32'h0000_0010, 32'h0);
        do_req(1'b0, 32'h0001_0010, 32'h0);
        do_req(1'b0, 32'h0000_0010, 32'h0);

        // Reset in the middle of a refill
        @(posedge clk);
        #1;
        auto_rd      = 1'b0;
        mem_rd_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_7052;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_rd_req && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_rd_req", mem_rd_req, 1);
        check("mid_rd_addr", mem_rd_addr, 28'h000_0705);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rd_req", mem_rd_req, 0);
        check("abort_rd_addr", mem_rd_addr, 0);
        check("abort_req_ready", req_ready, 1);
        model_reset();
`ifdef CACHE_STATS_EN
        check("abort_hit_cnt", hit_cnt, 0);
        check("abort_miss_cnt", miss_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rd_valid = 1'b1;
        mem_rd_data  = {WORDS{32'hBAD0_BAD0}};
        @(negedge clk);
        mem_rd_valid = 1'b0;
        check("late_fill_req_ready", req_ready, 1);
        check("late_fill_rd_req", mem_rd_req, 0);
        @(posedge clk);
        #1;
        auto_rd = 1'b1;
        do_req(1'b0, 32'h0000_7052, 32'h0);
        do_req(1'b0, 32'h0000_7052, 32'h0);

        // Randomized traffic over a few tags and edge indices/offsets
        for (int k = 0; k < 300; k++) begin
            logic [TAG_W-1:0] t;
            logic [IDX_W-1:0] ix;
            logic [OFF_W-1:0] of;
            t = TAG_W'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       ix = '0;
                1:       ix = IDX_W'(1);
                2:       ix = IDX_W'(BLOCKS - 1);
                default: ix = IDX_W'($urandom_range(0, 7));
            endcase
            of = ($urandom_range(0, 3) == 0) ? OFF_W'(WORDS - 1) : OFF_W'($urandom_range(0, WORDS - 1));
            a  = {t, ix, of};
            do_req($urandom_range(0, 2) == 0, a, $urandom);
        end

        repeat (4) @(negedge clk);
        check("rsp_q_drained", exp_rsp_q.size(), 0);
        check("rd_q_drained", exp_rd_q.size(), 0);
        check("wr_q_drained", exp_wr_q.size(), 0);
`ifdef CACHE_STATS_EN
        check("final_hit_cnt", hit_cnt, exp_hits);
        check("final_miss_cnt", miss_cnt, exp_misses);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dm_cache_ctrl.md
DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 The block SHALL have parameter BLOCKS, default 256: number of cache lines, a power of two.
REQ-002 The block SHALL have parameter WORDS, default 16: words per line, a power of two.
REQ-003 The block SHALL have parameter SIZE, default 32: word width in bits.
REQ-004 The block SHALL have parameter ADDR_W, default 32: word-address width; tag width TAG_W = ADDR_W - log2(BLOCKS) - log2(WORDS).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports in this order:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
REQ-006 The block SHALL have these request-side ports:
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address, split {tag, index, offset}.
- req_wdata  in  SIZE  write data.
- rsp_valid  out  1  one-cycle pulse: read data valid, or write acknowledged.
- rsp_rdata  out  SIZE  read data.
REQ-007 The block SHALL have these memory-side ports:
- mem_rd_req  out  1  line fetch request.
- mem_rd_addr  out  ADDR_W-log2(WORDS)  line address.
- mem_rd_valid  in  1  fill data present.
- mem_rd_data  in  SIZE*WORDS  line data; word 0 in the LSBs.
- mem_wr_valid  out  1  write-through request.
- mem_wr_addr  out  ADDR_W  word address.
- mem_wr_data  out  SIZE  write data.
- mem_wr_ready  in  1  write accepted.

Function
REQ-008 Storage SHALL be BLOCKS lines, each holding one valid bit, a TAG_W tag and WORDS×SIZE data; mapping is direct (one line per index).
REQ-009 The FSM SHALL have four states: IDLE, LOOKUP, REFILL and WRITE; req_ready SHALL be 1 only in IDLE.
REQ-010 In IDLE, the request SHALL be latched when req_valid is 1; the next state is LOOKUP.
REQ-011 In LOOKUP, hit SHALL be defined as valid[index] AND tag[index] equal to the request tag.
REQ-012 LOOKUP, read hit: the addressed word SHALL be registered to rsp_rdata, rsp_valid pulses high on the next cycle, and the FSM returns to IDLE (response 2 edges after acceptance).
REQ-013 LOOKUP, read miss: the next state SHALL be REFILL.
- mem_rd_req = 1, with mem_rd_addr = {tag, index}.
REQ-014 REFILL: mem_rd_req and mem_rd_addr SHALL be held until mem_rd_valid = 1.
- Then the line is written, tag and valid set, and the FSM returns to LOOKUP, which now hits.
- mem_rd_valid may arrive in the same cycle mem_rd_req first rises.
REQ-015 LOOKUP, write: the policy SHALL be write-through, no-write-allocate.
- On a hit, the addressed word in the line is updated.
- On a miss, the cache is unchanged.
- In both cases the next state is WRITE.
REQ-016 WRITE: mem_wr_valid, mem_wr_addr and mem_wr_data SHALL be held stable until mem_wr_ready = 1.
- Then rsp_valid pulses once, rsp_rdata = 0, and the FSM returns to IDLE.
REQ-017 Offset SHALL select bits [offset*SIZE +: SIZE]; index 0, index BLOCKS-1 and offset WORDS-1 SHALL behave like any other value.
REQ-018 mem_rd_valid outside REFILL and mem_wr_ready outside WRITE SHALL be ignored.

Reset
REQ-019 While rst_n = 0, regardless of clk, the block SHALL:
- clear every valid bit;
- put the FSM in IDLE;
- drive all outputs to 0, except req_ready, which is 1 once in IDLE.
REQ-020 A reset during REFILL or WRITE SHALL abandon the transaction, with no response and no line update; mem_rd_req and mem_wr_valid drop immediately.

Configuration
REQ-021 When macro CACHE_STATS_EN is defined, the block SHALL add two outputs:
- hit_cnt  out  32  incremented once per LOOKUP hit on the original access only (the post-refill re-LOOKUP is not counted);
- miss_cnt  out  32  incremented once per LOOKUP miss.
Both counters saturate at 32'hFFFF_FFFF and are cleared by reset.
REQ-022 When CACHE_STATS_EN is undefined, the block SHALL have neither these ports nor this logic, with all other behaviour identical.

Verification
REQ-023 Read 0x0000_0013 after reset -> miss.
- mem_rd_req with mem_rd_addr = 0x000_0001.
- Fill word3 = 0xDEAD_BEEF.
- rsp_rdata = 0xDEAD_BEEF.
- Repeat the read -> hit, no mem_rd_req, rsp_valid 2 edges after acceptance.
REQ-024 Write 0x1234_5678 to 0x0000_0013 after the fill -> cached word updated.
- mem_wr_valid held for 3 cycles while mem_wr_ready = 0.
- Ack after ready.
- A re-read returns 0x1234_5678 as a hit.
REQ-025 Write to an uncached address 0x0000_5000 -> mem_wr only; a subsequent read misses.
REQ-026 Conflict: read 0x0000_0010, then read 0x0001_0010 (same index 1, different tag) -> both miss; a read of 0x0000_0010 then misses again.
REQ-027 Assert rst_n = 0 mid-REFILL -> mem_rd_req = 0 at once.
- A late mem_rd_valid is ignored.
- The next read of the same address misses.
- With CACHE_STATS_EN: hit_cnt = miss_cnt = 0 after reset.
